stopwatch_bcd_counter: RTL and testbench

STOPWATCH_BCD_COUNTER -- requirements
Module: stopwatch_bcd_counter

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/button_debouncer.sv | 49 ++++
 rtl/stopwatch_bcd_counter.sv | 103 ++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state type, BCD digit limits and digit-increment helper
// for the stopwatch counter.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED
    } state_t;

    localparam logic [3:0] CS_UNITS_MAX = 4'd9;
    localparam logic [3:0] CS_TENS_MAX  = 4'd9;
    localparam logic [3:0] S_UNITS_MAX  = 4'd9;
    localparam logic [3:0] S_TENS_MAX   = 4'd5;

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d == max) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, consecutive-cycle debouncer and rising-edge
// detector producing a one-cycle press event for a raw push button.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [1:0]    r_fill;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_fill    <= {r_fill[0], 1'b1};
            // a button held through reset must be seen released before it can fire
            r_armed   <= r_armed | (r_fill[1] & ~r_sync[1]);
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_level & ~r_level_d & r_armed;

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: 00.00-59.99 BCD stopwatch with start/stop and clear buttons,
// prescaled 10 ms tick, IDLE/RUNNING/PAUSED control and a rollover pulse.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = 1_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] x,
    output logic        running,
    output logic        wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_x;
    logic          r_running;
    logic          r_wrap;
    logic          w_ss;
    logic          w_clr;
    logic          w_clear_go;
    logic          w_tick;
    logic          w_c0;
    logic          w_c1;
    logic          w_c2;
    logic          w_last;
    logic [15:0]   w_x_inc;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_start_stop),
        .o_press (w_ss)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_clear),
        .o_press (w_clr)
    );

    assign w_tick = (r_state == RUNNING) && (r_presc == PRESC_MAX);

    // cascaded BCD carries: each digit advances only when all lower digits are at max
    assign w_c0   = r_x[3:0] == CS_UNITS_MAX;
    assign w_c1   = w_c0 && (r_x[7:4] == CS_TENS_MAX);
    assign w_c2   = w_c1 && (r_x[11:8] == S_UNITS_MAX);
    assign w_last = w_c2 && (r_x[15:12] == S_TENS_MAX);
    assign w_x_inc = {
        w_c2 ? digit_inc(r_x[15:12], S_TENS_MAX)  : r_x[15:12],
        w_c1 ? digit_inc(r_x[11:8],  S_UNITS_MAX) : r_x[11:8],
        w_c0 ? digit_inc(r_x[7:4],   CS_TENS_MAX) : r_x[7:4],
        digit_inc(r_x[3:0], CS_UNITS_MAX)
    };

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_ss && !w_clr) ? RUNNING : IDLE;
            RUNNING: w_next = w_ss ? PAUSED : RUNNING;
            PAUSED:  w_next = w_clr ? IDLE : (w_ss ? RUNNING : PAUSED);
            default: w_next = IDLE;
        endcase
    end

    assign w_clear_go = w_clr && (r_state != RUNNING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_x       <= '0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == RUNNING);
            r_wrap    <= w_tick && w_last;
            if (w_clear_go) begin
                r_presc <= '0;
                r_x     <= '0;
            end else if (r_state == RUNNING) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick)
                    r_x <= w_x_inc;
            end
        end
    end

    assign x       = r_x;
    assign running = r_running;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: directed scenarios with TICK_DIV=4, DEBOUNCE_CYCLES=3;
// expected outputs are queued with a due cycle and compared when that cycle arrives.
module tb_stopwatch_bcd_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_ss;
    logic        btn_clr;
    logic [15:0] x;
    logic        running;
    logic        wrap;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int base  = 0;

    typedef struct {
        int          due;
        string       tag;
        logic [15:0] x;
        logic        run;
        logic        wrap;
    } exp_t;

    exp_t q[$];
    exp_t e_cur;

    stopwatch_bcd_counter #(.TICK_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_start_stop (btn_ss),
        .btn_clear      (btn_clr),
        .x              (x),
        .running        (running),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic drain();
        while (q.size() > 0 && q[0].due <= cyc) begin
            e_cur = q.pop_front();
            chk({e_cur.tag, "/x"}, x, e_cur.x);
            chk({e_cur.tag, "/running"}, {15'd0, running}, {15'd0, e_cur.run});
            chk({e_cur.tag, "/wrap"}, {15'd0, wrap}, {15'd0, e_cur.wrap});
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            drain();
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < base + t) begin
            @(negedge clk);
            drain();
        end
    endtask

    task automatic exp_at(input int t, input string tag, input logic [15:0] ex,
                          input logic er, input logic ew);
        q.push_back('{base + t, tag, ex, er, ew});
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(3);
        base = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        wait_cyc(3);
        chk("reset/x", x, 16'h0000);
        chk("reset/running", {15'd0, running}, 16'd0);
        chk("reset/wrap", {15'd0, wrap}, 16'd0);
        rst_n = 1'b1;
        wait_cyc(3);
        base = cyc;

        // clean start press, held button gives one event
        exp_at(5,  "a_pre_event", 16'h0000, 1'b0, 1'b0);
        exp_at(6,  "a_running",   16'h0000, 1'b1, 1'b0);
        exp_at(9,  "a_pre_tick",  16'h0000, 1'b1, 1'b0);
        exp_at(10, "a_first",     16'h0001, 1'b1, 1'b0);
        exp_at(46, "a_ten",       16'h0010, 1'b1, 1'b0);
        btn_ss = 1'b1;
        wait_to(8);
        btn_ss = 1'b0;
        wait_to(46);

        // bouncing press then held
        do_reset();
        exp_at(12, "b_bounce", 16'h0000, 1'b0, 1'b0);
        exp_at(15, "b_pre",    16'h0000, 1'b0, 1'b0);
        exp_at(16, "b_run",    16'h0000, 1'b1, 1'b0);
        exp_at(40, "b_held",   16'h0006, 1'b1, 1'b0);
        btn_ss = 1'b1;
        for (int i = 1; i < 10; i++) begin
            wait_to(i);
            btn_ss = (i % 2 == 0);
        end
        wait_to(10);
        btn_ss = 1'b1;
        wait_to(40);
        btn_ss = 1'b0;

        // count through carries to rollover
        do_reset();
        exp_at(6,     "c_run",      16'h0000, 1'b1, 1'b0);
        exp_at(406,   "c_1s",       16'h0100, 1'b1, 1'b0);
        exp_at(4006,  "c_10s",      16'h1000, 1'b1, 1'b0);
        exp_at(23998, "c_5998",     16'h5998, 1'b1, 1'b0);
        exp_at(24002, "c_5999",     16'h5999, 1'b1, 1'b0);
        exp_at(24005, "c_hold",     16'h5999, 1'b1, 1'b0);
        exp_at(24006, "c_wrap",     16'h0000, 1'b1, 1'b1);
        exp_at(24007, "c_wrap_end", 16'h0000, 1'b1, 1'b0);
        exp_at(24010, "c_resume",   16'h0001, 1'b1, 1'b0);
        btn_ss = 1'b1;
        wait_to(8);
        btn_ss = 1'b0;
        wait_to(24010);

        // pause at 01.23, clear, restart from zeroed prescaler, clear ignored while running
        do_reset();
        exp_at(6,   "d_run",         16'h0000, 1'b1, 1'b0);
        exp_at(498, "d_123",         16'h0123, 1'b1, 1'b0);
        exp_at(500, "d_paused",      16'h0123, 1'b0, 1'b0);
        exp_at(520, "d_pause_hold",  16'h0123, 1'b0, 1'b0);
        exp_at(525, "d_pre_clr",     16'h0123, 1'b0, 1'b0);
        exp_at(526, "d_clr",         16'h0000, 1'b0, 1'b0);
        exp_at(546, "d_restart",     16'h0000, 1'b1, 1'b0);
        exp_at(549, "d_presc_zero",  16'h0000, 1'b1, 1'b0);
        exp_at(550, "d_first",       16'h0001, 1'b1, 1'b0);
        exp_at(580, "d_clr_ignored", 16'h0008, 1'b1, 1'b0);
        btn_ss = 1'b1;
        wait_to(8);
        btn_ss = 1'b0;
        wait_to(494);
        btn_ss = 1'b1;
        wait_to(502);
        btn_ss = 1'b0;
        wait_to(520);
        btn_clr = 1'b1;
        wait_to(528);
        btn_clr = 1'b0;
        wait_to(540);
        btn_ss = 1'b1;
        wait_to(548);
        btn_ss = 1'b0;
        wait_to(560);
        btn_clr = 1'b1;
        wait_to(568);
        btn_clr = 1'b0;
        wait_to(580);

        // simultaneous presses while paused and while running; tick at pausing edge
        do_reset();
        exp_at(25,  "e_pre_pause",   16'h0004, 1'b1, 1'b0);
        exp_at(26,  "e_pause_tick",  16'h0005, 1'b0, 1'b0);
        exp_at(30,  "e_paused",      16'h0005, 1'b0, 1'b0);
        exp_at(45,  "e_pre_both",    16'h0005, 1'b0, 1'b0);
        exp_at(46,  "e_both_paused", 16'h0000, 1'b0, 1'b0);
        exp_at(66,  "e_run2",        16'h0000, 1'b1, 1'b0);
        exp_at(86,  "e_both_run",    16'h0005, 1'b0, 1'b0);
        exp_at(100, "e_held",        16'h0005, 1'b0, 1'b0);
        btn_ss = 1'b1;
        wait_to(8);
        btn_ss = 1'b0;
        wait_to(20);
        btn_ss = 1'b1;
        wait_to(28);
        btn_ss = 1'b0;
        wait_to(40);
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        wait_to(48);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        wait_to(60);
        btn_ss = 1'b1;
        wait_to(68);
        btn_ss = 1'b0;
        wait_to(80);
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        wait_to(88);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        wait_to(100);

        // asynchronous reset mid-count
        do_reset();
        exp_at(1394, "f_347", 16'h0347, 1'b1, 1'b0);
        btn_ss = 1'b1;
        wait_to(8);
        btn_ss = 1'b0;
        wait_to(1394);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_async/x", x, 16'h0000);
        chk("f_async/running", {15'd0, running}, 16'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        base = cyc;
        exp_at(30, "f_idle", 16'h0000, 1'b0, 1'b0);
        wait_to(30);

        // button held through reset release
        rst_n  = 1'b0;
        btn_ss = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        base = cyc;
        exp_at(20, "g_held_no_event", 16'h0000, 1'b0, 1'b0);
        exp_at(35, "g_pre",           16'h0000, 1'b0, 1'b0);
        exp_at(36, "g_press",         16'h0000, 1'b1, 1'b0);
        wait_to(20);
        btn_ss = 1'b0;
        wait_to(30);
        btn_ss = 1'b1;
        wait_to(38);
        btn_ss = 1'b0;
        wait_to(40);

        wait_cyc(2);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
